id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline boundary of the 5-stage core. Captures register-file read data (RD1/RD2) and decoded control for the instruction in ID and presents them registered to EX.
- Contains load-use hazard detection: stalls IF/ID and inserts a bubble into EX.
- Honours branch flush from EX and a hold request from the memory stage.
- Keeps saturating performance counters for bubbles and holds.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of ID instruction
id_rd1  in  XLEN  RF read data, port 1
id_rd2  in  XLEN  RF read data, port 2
id_imm  in  XLEN  decoded immediate
id_rs1  in  AW  source reg 1 (RF A1)
id_rs2  in  AW  source reg 2 (RF A2)
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  AW  destination register
id_ctrl  in  12  {regwrite, memread, memwrite, alu_src, wdsel[1:0], alu_op[5:0]}
flush  in  1  taken branch/jump resolved in EX
hold  in  1  memory stage busy; freeze whole front-end
ex_valid  out  1  EX slot holds a real instruction
ex_pc, ex_rd1, ex_rd2, ex_imm  out  XLEN  registered copies
ex_rs1, ex_rs2, ex_rd  out  AW  registered copies
ex_ctrl  out  12  registered control
stall_ifid  out  1  freeze PC and IF/ID register this cycle
bubble_cnt  out  CNT_W  count of inserted load-use bubbles
hold_cnt  out  CNT_W  count of hold cycles

Behaviour:
- Reset is synchronous and active-high. On a rst edge:
  - ex_valid=0; all ex_* data, address and ctrl fields =0.
  - Both counters =0.
  - stall_ifid is forced 0 while rst=1.
- Load-use hazard is combinational from current state and ID inputs:
  - luh = id_valid & ex_valid & ex_ctrl.memread & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - stall_ifid = hold | (luh & ~flush).
- Per-edge update, in priority order:
  1. rst: clear as above.
  2. hold=1: all ex_* registers keep their values; hold_cnt+1, saturating. Flush and luh are ignored while hold=1; the upstream unit re-presents flush after hold drops.
  3. flush=1: ex_valid<=0 and ex_ctrl<=0, so the flushed instruction cannot write RF or memory. Data fields are don't-care; the implementation loads zero.
  4. luh=1: bubble. ex_valid<=0, ex_ctrl<=0; bubble_cnt+1, saturating. ID contents stay in place because stall_ifid=1, so the same instruction is re-presented next cycle.
  5. Otherwise: capture all id_* into ex_*; ex_valid<=id_valid. If id_valid=0, ex_ctrl<=0.
- Latency: one cycle from ID inputs to ex_* outputs. A load followed immediately by a dependent instruction costs exactly one bubble. A dependent instruction two or more slots behind costs nothing.
- x0 is never a hazard source: ex_rd==0 suppresses luh.
- A hazard on an unused operand field (rsN_used=0) is ignored.
- Both rs1 and rs2 matching ex_rd gives a single bubble, not two.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Same-cycle RF write/read bypass is provided by the register file. This block does no forwarding; EX-stage forwarding is a separate unit fed from ex_rs1/ex_rs2.
- A reset asserted during a stall or hold drops the stall the same cycle. After release, ex_valid=0 and the counters restart from 0.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> all ex_* =0, ex_valid=0, counters =0, stall_ifid=0.
2. Load x5 (memread=1, rd=5) then add using rs1=5, rs1_used=1 -> cycle 2: stall_ifid=1; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1. Cycle 3: the add is captured with ex_rd1 equal to the id_rd1 presented in cycle 3.
3. Load with rd=0 followed by a consumer with rs1=0 -> no stall, bubble_cnt stays 0. A consumer with rs2=5 but rs2_used=0 after a load to x5 -> no stall.
4. Load-use hazard and flush=1 in the same cycle -> stall_ifid=0, ex_valid<=0, bubble_cnt unchanged.
5. hold=1 for 3 cycles during a hazard -> ex_* frozen, stall_ifid=1, hold_cnt=3, bubble_cnt=0. After hold=0 -> one bubble, bubble_cnt=1.
6. CNT_W=4; force 20 bubbles -> bubble_cnt saturates at 15 and stays there.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register of the 5-stage core, with load-use hazard
//   detection and performance counters for bubbles and hold cycles.
//
//   Ports
//     clk, rst           rising-edge clock, synchronous active-high reset
//     id_*               instruction currently in ID (RF data, imm, regs, ctrl)
//     flush              taken branch/jump resolved in EX; kill the ID instruction
//     hold               memory stage busy; freeze the whole front-end
//     ex_*               registered copies presented to EX
//     stall_ifid         freeze PC and IF/ID this cycle
//     bubble_cnt         saturating count of inserted load-use bubbles
//     hold_cnt           saturating count of hold cycles
//
//   id_ctrl / ex_ctrl layout:
//     {regwrite, memread, memwrite, alu_src, wdsel[1:0], alu_op[5:0]}
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int AW    = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rd1,
  input  logic [XLEN-1:0]  id_rd2,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [AW-1:0]    id_rd,
  input  logic [11:0]      id_ctrl,
  input  logic             flush,
  input  logic             hold,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rd1,
  output logic [XLEN-1:0]  ex_rd2,
  output logic [XLEN-1:0]  ex_imm,
  output logic [AW-1:0]    ex_rs1,
  output logic [AW-1:0]    ex_rs2,
  output logic [AW-1:0]    ex_rd,
  output logic [11:0]      ex_ctrl,
  output logic             stall_ifid,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam int MEMREAD_BIT = 10;

  logic             valid_reg, valid_next;
  logic [XLEN-1:0]  pc_reg, pc_next;
  logic [XLEN-1:0]  rd1_reg, rd1_next;
  logic [XLEN-1:0]  rd2_reg, rd2_next;
  logic [XLEN-1:0]  imm_reg, imm_next;
  logic [AW-1:0]    rs1_reg, rs1_next;
  logic [AW-1:0]    rs2_reg, rs2_next;
  logic [AW-1:0]    rd_reg, rd_next;
  logic [11:0]      ctrl_reg, ctrl_next;

  logic luh;
  logic [1:0] cnt_inc;

  // A load in EX whose destination is a real register read by the ID
  // instruction. x0 never carries a dependency.
  always_comb begin
    luh = id_valid & valid_reg & ctrl_reg[MEMREAD_BIT] & (rd_reg != '0) &
          ((id_rs1_used & (id_rs1 == rd_reg)) |
           (id_rs2_used & (id_rs2 == rd_reg)));
  end

  // A flush kills the ID instruction, so stalling it would be pointless.
  assign stall_ifid = ~rst & (hold | (luh & ~flush));

  always_comb begin
    valid_next = valid_reg;
    pc_next    = pc_reg;
    rd1_next   = rd1_reg;
    rd2_next   = rd2_reg;
    imm_next   = imm_reg;
    rs1_next   = rs1_reg;
    rs2_next   = rs2_reg;
    rd_next    = rd_reg;
    ctrl_next  = ctrl_reg;
    if (hold) begin
      // keep everything
    end else if (flush || luh) begin
      // Bubble: zero the whole slot so a dead instruction has no side effects.
      valid_next = 1'b0;
      pc_next    = '0;
      rd1_next   = '0;
      rd2_next   = '0;
      imm_next   = '0;
      rs1_next   = '0;
      rs2_next   = '0;
      rd_next    = '0;
      ctrl_next  = '0;
    end else begin
      valid_next = id_valid;
      pc_next    = id_pc;
      rd1_next   = id_rd1;
      rd2_next   = id_rd2;
      imm_next   = id_imm;
      rs1_next   = id_rs1;
      rs2_next   = id_rs2;
      rd_next    = id_rd;
      ctrl_next  = id_valid ? id_ctrl : 12'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      rd1_reg   <= '0;
      rd2_reg   <= '0;
      imm_reg   <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      rd_reg    <= '0;
      ctrl_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      pc_reg    <= pc_next;
      rd1_reg   <= rd1_next;
      rd2_reg   <= rd2_next;
      imm_reg   <= imm_next;
      rs1_reg   <= rs1_next;
      rs2_reg   <= rs2_next;
      rd_reg    <= rd_next;
      ctrl_reg  <= ctrl_next;
    end
  end

  // Counter 0 counts bubbles, counter 1 counts hold cycles.
  assign cnt_inc[0] = ~hold & ~flush & luh;
  assign cnt_inc[1] = hold;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst)
          cnt_reg <= '0;
        else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}}))
          cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  endgenerate

  assign bubble_cnt = g_cnt[0].cnt_reg;
  assign hold_cnt   = g_cnt[1].cnt_reg;

  assign ex_valid = valid_reg;
  assign ex_pc    = pc_reg;
  assign ex_rd1   = rd1_reg;
  assign ex_rd2   = rd2_reg;
  assign ex_imm   = imm_reg;
  assign ex_rs1   = rs1_reg;
  assign ex_rs2   = rs2_reg;
  assign ex_rd    = rd_reg;
  assign ex_ctrl  = ctrl_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage (CNT_W=4 so saturation is reachable).
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int CNT_W = 4;

  localparam logic [11:0] CTRL_LOAD = 12'hC01; // regwrite, memread
  localparam logic [11:0] CTRL_ALU  = 12'h801; // regwrite only

  logic             clk;
  logic             rst;
  logic             id_valid;
  logic [XLEN-1:0]  id_pc, id_rd1, id_rd2, id_imm;
  logic [AW-1:0]    id_rs1, id_rs2, id_rd;
  logic             id_rs1_used, id_rs2_used;
  logic [11:0]      id_ctrl;
  logic             flush, hold;
  logic             ex_valid;
  logic [XLEN-1:0]  ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [AW-1:0]    ex_rs1, ex_rs2, ex_rd;
  logic [11:0]      ex_ctrl;
  logic             stall_ifid;
  logic [CNT_W-1:0] bubble_cnt, hold_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_bub  = 0;
  int exp_hold = 0;

  id_ex_stage #(.XLEN(XLEN), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_ctrl(id_ctrl), .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_ctrl(ex_ctrl), .stall_ifid(stall_ifid),
    .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] d1,
                     input logic [AW-1:0] r1, input logic u1,
                     input logic [AW-1:0] r2, input logic u2,
                     input logic [AW-1:0] rd, input logic [11:0] ctrl);
    id_valid = v; id_pc = pc; id_rd1 = d1; id_rd2 = d1 ^ 32'h0000FFFF;
    id_imm = pc + 32'd4; id_rs1 = r1; id_rs1_used = u1; id_rs2 = r2;
    id_rs2_used = u2; id_rd = rd; id_ctrl = ctrl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drv(1'b1, $urandom, $urandom, AW'($urandom), 1'b1, AW'($urandom), 1'b1,
          AW'($urandom), 12'($urandom));
      hold = 1'b1; flush = 1'($urandom);
      #1;
      n_checks++;
      if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall_ifid); end
      tick();
    end
    n_checks++;
    if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", ex_valid); end
    n_checks++;
    if ({ex_pc, ex_rd1, ex_rd2, ex_imm} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {ex_pc, ex_rd1, ex_rd2, ex_imm}); end
    n_checks++;
    if ({ex_rs1, ex_rs2, ex_rd, ex_ctrl} !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", {ex_rs1, ex_rs2, ex_rd, ex_ctrl}); end
    n_checks++;
    if (bubble_cnt !== 4'd0 || hold_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bubble_cnt, hold_cnt); end
    rst = 1'b0; hold = 1'b0; flush = 1'b0;
    drv(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 12'h0);
    tick();
    $display("test_reset done: ex_valid=%0b bubble_cnt=%0d hold_cnt=%0d", ex_valid, bubble_cnt, hold_cnt);
  endtask

  task automatic test_load_use();
    drv(1'b1, 32'h100, 32'hAAAA, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, CTRL_LOAD);
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd !== 5'd5 || ex_ctrl !== CTRL_LOAD || ex_pc !== 32'h100) begin
      n_fail++; $display("FAIL lu_load_capture: got v=%0b rd=%0d ctrl=%h pc=%h want 1/5/c01/100", ex_valid, ex_rd, ex_ctrl, ex_pc);
    end
    drv(1'b1, 32'h104, 32'h1111, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall_ifid); end
    tick();
    exp_bub++;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 12'h0 || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL lu_bubble: got v=%0b ctrl=%h cnt=%0d want 0/000/%0d", ex_valid, ex_ctrl, bubble_cnt, exp_bub);
    end
    drv(1'b1, 32'h104, 32'h2222, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL lu_stall_drop: got %0b want 0", stall_ifid); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd1 !== 32'h2222 || ex_rd2 !== 32'h0000DDDD || ex_imm !== 32'h108 ||
        ex_rs1 !== 5'd5 || ex_ctrl !== CTRL_ALU || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL lu_consumer: got v=%0b rd1=%h rd2=%h imm=%h rs1=%0d ctrl=%h cnt=%0d", ex_valid, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_ctrl, bubble_cnt);
    end
    $display("test_load_use done: bubble_cnt=%0d ex_rd1=%h", bubble_cnt, ex_rd1);
  endtask

  task automatic test_no_hazard();
    // load to x0, consumer of x0
    drv(1'b1, 32'h200, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h204, 32'h3333, 5'd0, 1'b1, 5'd0, 1'b1, 5'd7, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL nh_x0_stall: got %0b want 0", stall_ifid); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h204 || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL nh_x0_capture: got v=%0b pc=%h cnt=%0d want 1/204/%0d", ex_valid, ex_pc, bubble_cnt, exp_bub);
    end
    // load x5, consumer names x5 in rs2 but does not read it
    drv(1'b1, 32'h208, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h20C, 32'h4444, 5'd3, 1'b1, 5'd5, 1'b0, 5'd8, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL nh_unused_stall: got %0b want 0", stall_ifid); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h20C || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL nh_unused_capture: got v=%0b pc=%h cnt=%0d", ex_valid, ex_pc, bubble_cnt);
    end
    // load x5, independent, then dependent two slots behind
    drv(1'b1, 32'h210, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h214, 32'h0, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, CTRL_ALU);
    tick();
    drv(1'b1, 32'h218, 32'h5555, 5'd5, 1'b1, 5'd5, 1'b1, 5'd10, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL nh_distance2_stall: got %0b want 0", stall_ifid); end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_rd1 !== 32'h5555 || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL nh_distance2_capture: got v=%0b rd1=%h cnt=%0d", ex_valid, ex_rd1, bubble_cnt);
    end
    $display("test_no_hazard done: bubble_cnt=%0d", bubble_cnt);
  endtask

  task automatic test_flush();
    drv(1'b1, 32'h300, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h304, 32'h6666, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, CTRL_ALU);
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %0b want 0", stall_ifid); end
    tick();
    flush = 1'b0;
    n_checks++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 12'h0 || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL flush_kill: got v=%0b ctrl=%h cnt=%0d want 0/000/%0d", ex_valid, ex_ctrl, bubble_cnt, exp_bub);
    end
    $display("test_flush done: ex_valid=%0b bubble_cnt=%0d", ex_valid, bubble_cnt);
  endtask

  task automatic test_hold();
    drv(1'b1, 32'h400, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd9, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h404, 32'h7777, 5'd2, 1'b1, 5'd9, 1'b1, 5'd12, CTRL_ALU);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (stall_ifid !== 1'b1) begin n_fail++; $display("FAIL hold_stall[%0d]: got %0b want 1", i, stall_ifid); end
      tick();
      exp_hold++;
      n_checks++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h400 || ex_rd !== 5'd9 || ex_ctrl !== CTRL_LOAD) begin
        n_fail++; $display("FAIL hold_frozen[%0d]: got v=%0b pc=%h rd=%0d ctrl=%h want 1/400/9/c01", i, ex_valid, ex_pc, ex_rd, ex_ctrl);
      end
    end
    n_checks++;
    if (hold_cnt !== 4'(exp_hold) || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL hold_cnt: got hold=%0d bub=%0d want %0d/%0d", hold_cnt, bubble_cnt, exp_hold, exp_bub);
    end
    hold = 1'b0;
    #1;
    n_checks++;
    if (stall_ifid !== 1'b1) begin n_fail++; $display("FAIL hold_release_stall: got %0b want 1", stall_ifid); end
    tick();
    exp_bub++;
    n_checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 4'(exp_bub) || hold_cnt !== 4'(exp_hold)) begin
      n_fail++; $display("FAIL hold_bubble: got v=%0b bub=%0d hold=%0d want 0/%0d/%0d", ex_valid, bubble_cnt, hold_cnt, exp_bub, exp_hold);
    end
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h404 || ex_rs2 !== 5'd9) begin
      n_fail++; $display("FAIL hold_consumer: got v=%0b pc=%h rs2=%0d want 1/404/9", ex_valid, ex_pc, ex_rs2);
    end
    $display("test_hold done: hold_cnt=%0d bubble_cnt=%0d", hold_cnt, bubble_cnt);
  endtask

  task automatic test_both_operands();
    drv(1'b1, 32'h500, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h504, 32'h8888, 5'd4, 1'b1, 5'd4, 1'b1, 5'd13, CTRL_ALU);
    tick();
    exp_bub++;
    tick();
    n_checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h504 || bubble_cnt !== 4'(exp_bub)) begin
      n_fail++; $display("FAIL both_ops: got v=%0b pc=%h cnt=%0d want 1/504/%0d", ex_valid, ex_pc, bubble_cnt, exp_bub);
    end
    $display("test_both_operands done: bubble_cnt=%0d", bubble_cnt);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 20; i++) begin
      drv(1'b1, 32'h600, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd6, CTRL_LOAD);
      tick();
      drv(1'b1, 32'h604, 32'h0, 5'd6, 1'b1, 5'd0, 1'b0, 5'd14, CTRL_ALU);
      tick();
      if (exp_bub < 15) exp_bub++;
    end
    n_checks++;
    if (bubble_cnt !== 4'(exp_bub)) begin n_fail++; $display("FAIL sat_bubble: got %0d want %0d", bubble_cnt, exp_bub); end
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (exp_hold < 15) exp_hold++;
    end
    hold = 1'b0;
    n_checks++;
    if (hold_cnt !== 4'(exp_hold)) begin n_fail++; $display("FAIL sat_hold: got %0d want %0d", hold_cnt, exp_hold); end
    $display("test_saturation done: bubble_cnt=%0d hold_cnt=%0d", bubble_cnt, hold_cnt);
  endtask

  task automatic test_reset_during_stall();
    drv(1'b1, 32'h700, 32'h0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd3, CTRL_LOAD);
    tick();
    drv(1'b1, 32'h704, 32'h0, 5'd3, 1'b1, 5'd0, 1'b0, 5'd15, CTRL_ALU);
    #1;
    n_checks++;
    if (stall_ifid !== 1'b1) begin n_fail++; $display("FAIL rst_stall_pre: got %0b want 1", stall_ifid); end
    rst = 1'b1; hold = 1'b1;
    #1;
    n_checks++;
    if (stall_ifid !== 1'b0) begin n_fail++; $display("FAIL rst_stall_drop: got %0b want 0", stall_ifid); end
    tick();
    rst = 1'b0; hold = 1'b0;
    exp_bub = 0; exp_hold = 0;
    drv(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 12'h0);
    #1;
    n_checks++;
    if (ex_valid !== 1'b0 || bubble_cnt !== 4'd0 || hold_cnt !== 4'd0 || stall_ifid !== 1'b0) begin
      n_fail++; $display("FAIL rst_after_stall: got v=%0b bub=%0d hold=%0d stall=%0b want 0/0/0/0", ex_valid, bubble_cnt, hold_cnt, stall_ifid);
    end
    $display("test_reset_during_stall done: ex_valid=%0b", ex_valid);
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    drv(1'b0, 0, 0, 0, 1'b0, 0, 1'b0, 0, 12'h0);
    #2;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_hold();
    test_both_operands();
    test_saturation();
    test_reset_during_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
